// File: rtl/alarme_ctrl.sv
// Alarm ringing controller: detects the start of a time/alarm match and runs
// the ring / snooze / stop sequence. All timing is counted in 1 Hz ticks.
// State, timer, phase and snooze count update on the edge that samples the
// inputs; the output flops then follow one clock later.
module alarme_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       match,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_cnt
);

  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int TW       = $clog2(MAX_SECS + 1);

  localparam logic [TW-1:0] RING_LOAD   = TW'(RING_SECS);
  localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_SECS);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
  localparam logic [3:0]    MAX_CNT     = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [3:0]    cnt_r, cnt_s;
  logic          phase_r, phase_s;
  logic          match_d_r;
  logic          match_rise_s;

  logic          buzzer_r;
  logic          ringing_r;
  logic          snoozing_r;
  logic [3:0]    snooze_cnt_r;

  // Only a fresh 0->1 edge of the comparator may start a ring.
  assign match_rise_s = match & ~match_d_r;

  // Next-state logic: transitions are checked in priority order.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    cnt_s   = cnt_r;
    phase_s = phase_r;
    if (!arm) begin
      state_s = ST_DISARMED;
      timer_s = TIMER_ZERO;
      cnt_s   = 4'd0;
      phase_s = 1'b0;
    end else begin
      case (state_r)
        ST_DISARMED: begin
          state_s = ST_ARMED;
        end
        ST_ARMED: begin
          if (match_rise_s) begin
            state_s = ST_RINGING;
            timer_s = RING_LOAD;
            cnt_s   = 4'd0;
            phase_s = 1'b1;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_RINGING: begin
          if (stop) begin
            state_s = ST_ARMED;
            cnt_s   = 4'd0;
          end else if (snooze && (cnt_r < MAX_CNT)) begin
            state_s = ST_SNOOZE;
            timer_s = SNOOZE_LOAD;
            cnt_s   = cnt_r + 4'd1;
          end else if (tick_1hz) begin
            if (timer_r == TIMER_ONE) begin
              state_s = ST_ARMED;
              cnt_s   = 4'd0;
            end else begin
              timer_s = timer_r - TIMER_ONE;
              phase_s = ~phase_r;
            end
          end else begin
            state_s = ST_RINGING;
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_s = ST_ARMED;
            cnt_s   = 4'd0;
          end else if (tick_1hz) begin
            if (timer_r == TIMER_ONE) begin
              state_s = ST_RINGING;
              timer_s = RING_LOAD;
              phase_s = 1'b1;
            end else begin
              timer_s = timer_r - TIMER_ONE;
            end
          end else begin
            state_s = ST_SNOOZE;
          end
        end
        default: begin
          state_s = ST_DISARMED;
          timer_s = TIMER_ZERO;
          cnt_s   = 4'd0;
          phase_s = 1'b0;
        end
      endcase
    end
  end

  // Sequence state, timer, snooze count, buzzer phase and match history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_DISARMED;
      timer_r   <= TIMER_ZERO;
      cnt_r     <= 4'd0;
      phase_r   <= 1'b0;
      match_d_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      cnt_r     <= cnt_s;
      phase_r   <= phase_s;
      match_d_r <= match;
    end
  end

  // Output flops decoded from the registered state, so no input reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzzer_r     <= 1'b0;
      ringing_r    <= 1'b0;
      snoozing_r   <= 1'b0;
      snooze_cnt_r <= 4'd0;
    end else begin
      buzzer_r     <= (state_r == ST_RINGING) & phase_r;
      ringing_r    <= (state_r == ST_RINGING);
      snoozing_r   <= (state_r == ST_SNOOZE);
      snooze_cnt_r <= cnt_r;
    end
  end

  assign buzzer     = buzzer_r;
  assign ringing    = ringing_r;
  assign snoozing   = snoozing_r;
  assign snooze_cnt = snooze_cnt_r;

endmodule

// File: tb/tb_alarme_ctrl.sv
// Directed bench for alarme_ctrl with RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2.
module tb_alarme_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       match = 1'b0;
  logic       arm = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_cnt;

  int vectors = 0;
  int errs    = 0;

  alarme_ctrl #(
    .RING_SECS  (4),
    .SNOOZE_SECS(3),
    .MAX_SNOOZE (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .match     (match),
    .arm       (arm),
    .snooze    (snooze),
    .stop      (stop),
    .buzzer    (buzzer),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .snooze_cnt(snooze_cnt)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One-clock tick followed by nine idle clocks (tick every 10 clks).
  task automatic tick();
    tick_1hz = 1'b1;
    clk1();
    tick_1hz = 1'b0;
    repeat (9) clk1();
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk1("rst_buzzer", buzzer, 1'b0);
    chk1("rst_ringing", ringing, 1'b0);
    chk1("rst_snoozing", snoozing, 1'b0);
    chk4("rst_cnt", snooze_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clk1();

    // Arm, then match rises: ringing one clk after the match clk
    arm = 1'b1;
    clk1();
    clk1();
    match = 1'b1;
    clk1();
    chk1("ring_latency_0", ringing, 1'b0);
    clk1();
    chk1("ring_latency_1", ringing, 1'b1);
    chk1("buzz_t0", buzzer, 1'b1);
    tick();
    chk1("buzz_t1", buzzer, 1'b0);
    tick();
    chk1("buzz_t2", buzzer, 1'b1);
    tick();
    chk1("buzz_t3", buzzer, 1'b0);
    chk1("ring_t3", ringing, 1'b1);
    tick();
    chk1("timeout_ringing", ringing, 1'b0);
    chk4("timeout_cnt", snooze_cnt, 4'd0);
    repeat (5) clk1();
    chk1("no_retrigger_held", ringing, 1'b0);

    // New rising edge, then snooze sequence
    match = 1'b0;
    clk1();
    match = 1'b1;
    clk1();
    clk1();
    chk1("ring2", ringing, 1'b1);
    snooze = 1'b1;
    clk1();
    snooze = 1'b0;
    clk1();
    chk1("snz1_snoozing", snoozing, 1'b1);
    chk4("snz1_cnt", snooze_cnt, 4'd1);
    chk1("snz1_buzzer", buzzer, 1'b0);
    chk1("snz1_ringing", ringing, 1'b0);
    tick();
    tick();
    chk1("snz1_still", snoozing, 1'b1);
    tick();
    chk1("snz1_end_ringing", ringing, 1'b1);
    chk1("snz1_end_buzzer", buzzer, 1'b1);
    chk1("snz1_end_snoozing", snoozing, 1'b0);
    snooze = 1'b1;
    clk1();
    snooze = 1'b0;
    clk1();
    chk4("snz2_cnt", snooze_cnt, 4'd2);
    chk1("snz2_snoozing", snoozing, 1'b1);
    repeat (3) tick();
    chk1("snz2_end_ringing", ringing, 1'b1);
    snooze = 1'b1;
    clk1();
    snooze = 1'b0;
    clk1();
    chk1("snz3_ignored_ringing", ringing, 1'b1);
    chk1("snz3_ignored_snoozing", snoozing, 1'b0);
    chk4("snz3_cnt", snooze_cnt, 4'd2);

    // Stop and snooze together: stop wins
    stop = 1'b1;
    snooze = 1'b1;
    clk1();
    stop = 1'b0;
    snooze = 1'b0;
    clk1();
    chk1("stop_ringing", ringing, 1'b0);
    chk1("stop_snoozing", snoozing, 1'b0);
    chk4("stop_cnt", snooze_cnt, 4'd0);
    repeat (5) clk1();
    chk1("stop_no_retrigger", ringing, 1'b0);
    match = 1'b0;
    clk1();
    match = 1'b1;
    clk1();
    clk1();
    chk1("rering", ringing, 1'b1);

    // Timer=1: tick and snooze in the same clk, snooze wins
    repeat (3) tick();
    chk1("pre_tie_ringing", ringing, 1'b1);
    tick_1hz = 1'b1;
    snooze = 1'b1;
    clk1();
    tick_1hz = 1'b0;
    snooze = 1'b0;
    clk1();
    chk1("tie_snoozing", snoozing, 1'b1);
    chk4("tie_cnt", snooze_cnt, 4'd1);

    // Disarm during snooze
    arm = 1'b0;
    clk1();
    clk1();
    chk1("disarm_snoozing", snoozing, 1'b0);
    chk1("disarm_ringing", ringing, 1'b0);
    chk1("disarm_buzzer", buzzer, 1'b0);
    chk4("disarm_cnt", snooze_cnt, 4'd0);

    // Arm while match already 1: no ring
    arm = 1'b1;
    repeat (5) clk1();
    chk1("arm_on_match", ringing, 1'b0);
    match = 1'b0;
    clk1();
    match = 1'b1;
    clk1();
    clk1();
    chk1("ring_after_arm", ringing, 1'b1);

    // Asynchronous reset mid-ring (with nonzero snooze count)
    snooze = 1'b1;
    clk1();
    snooze = 1'b0;
    repeat (3) tick();
    chk1("pre_rst_ringing", ringing, 1'b1);
    chk4("pre_rst_cnt", snooze_cnt, 4'd1);
    chk1("pre_rst_buzzer", buzzer, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_buzzer", buzzer, 1'b0);
    chk1("async_rst_ringing", ringing, 1'b0);
    chk4("async_rst_cnt", snooze_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) clk1();
    chk1("post_rst_ringing", ringing, 1'b0);
    chk1("post_rst_snoozing", snoozing, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
